// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control slice.
// Holds the hazard-sequencer state encoding and the register-compare helper.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pipe_state_e;

    // A source operand collides with rd only when it is actually read.
    function automatic logic src_match(input logic uses,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd);
        return uses & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline stall/flush event counters.
// Sticks at all-ones instead of wrapping; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_r <= '0;
        end else if (inc_i && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the RV32I pipeline: load-use bubbles, taken-branch
// flushes and data-memory wait states, with event counters and a timeout error.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_pc_sel_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_en_o,
    output logic                  idex_flush_o,
    output logic                  exmem_en_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    pipe_state_e state_r, state_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic        load_use_s, mem_block_s, blocked_s;
    logic        pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s, err_s;
    logic        stall_inc_s;

    // x0 never creates a hazard since it is hard-wired to zero.
    assign load_use_s  = ex_is_load_i & (ex_rd_addr_i != REG_ZERO) &
                         (src_match(id_uses_rs1_i, id_rs1_addr_i, ex_rd_addr_i) |
                          src_match(id_uses_rs2_i, id_rs2_addr_i, ex_rd_addr_i));
    assign mem_block_s = mem_req_i & ~mem_ack_i;
    assign blocked_s   = (state_r == MEM_WAIT) ? ~mem_ack_i : mem_block_s;

    // State and wait-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            RUN: begin
                if (mem_block_s) begin
                    state_s    = MEM_WAIT;
                    wait_cnt_s = 8'd1;
                end else begin
                    state_s    = RUN;
                    wait_cnt_s = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_s    = RUN;
                    wait_cnt_s = 8'd0;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_s    = ERR;
                    wait_cnt_s = wait_cnt_r;
                end else begin
                    state_s    = MEM_WAIT;
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ERR: begin
                state_s    = ERR;
                wait_cnt_s = wait_cnt_r;
            end
            default: begin
                state_s    = RUN;
                wait_cnt_s = 8'd0;
            end
        endcase
    end

    // Mealy outputs; a release cycle from MEM_WAIT resolves branch/load-use like RUN.
    always_comb begin
        pc_en_s      = 1'b1;
        ifid_en_s    = 1'b1;
        ifid_flush_s = 1'b0;
        idex_en_s    = 1'b1;
        idex_flush_s = 1'b0;
        exmem_en_s   = 1'b1;
        err_s        = 1'b0;
        if (rst_i) begin
            err_s = 1'b0;
        end else if (state_r == ERR) begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
            err_s      = 1'b1;
        end else if (blocked_s) begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
        end else if (ex_pc_sel_i) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    assign pc_en_o      = pc_en_s;
    assign ifid_en_o    = ifid_en_s;
    assign ifid_flush_o = ifid_flush_s;
    assign idex_en_o    = idex_en_s;
    assign idex_flush_o = idex_flush_s;
    assign exmem_en_o   = exmem_en_s;
    assign err_o        = err_s;

    assign stall_inc_s = ~pc_en_s & (state_r != ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (stall_inc_s),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (ifid_flush_s),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Output vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, err
    localparam logic [6:0] O_IDLE   = 7'b1101010;
    localparam logic [6:0] O_LU     = 7'b0001110;
    localparam logic [6:0] O_BR     = 7'b1111110;
    localparam logic [6:0] O_BLOCK  = 7'b0000000;
    localparam logic [6:0] O_ERR    = 7'b0000001;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic id_uses_rs1_i, id_uses_rs2_i, ex_is_load_i, ex_pc_sel_i, mem_req_i, mem_ack_i;
    logic pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [6:0] outs_s;

    int tests_run = 0;
    int fails     = 0;

    // Behavioural model state
    bit m_err, m_wait;
    int m_wcnt, m_stall, m_flush;

    assign outs_s = {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, err_o};

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i), .ex_pc_sel_i(ex_pc_sel_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
        .idex_en_o(idex_en_o), .idex_flush_o(idex_flush_o), .exmem_en_o(exmem_en_o),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    function automatic logic [6:0] model_out();
        bit lu, blocked;
        if (rst_i) return O_IDLE;
        if (m_err) return O_ERR;
        blocked = m_wait ? !mem_ack_i : (mem_req_i && !mem_ack_i);
        if (blocked) return O_BLOCK;
        if (ex_pc_sel_i) return O_BR;
        lu = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
             ((id_uses_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
              (id_uses_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
        if (lu) return O_LU;
        return O_IDLE;
    endfunction

    task automatic model_update();
        logic [6:0] o;
        o = model_out();
        if (rst_i) begin
            m_err = 0; m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!o[6] && !m_err && m_stall < CNT_MAX) m_stall++;
            if (o[4] && m_flush < CNT_MAX) m_flush++;
            if (m_err) begin
                m_err = 1;
            end else if (m_wait) begin
                if (mem_ack_i) begin
                    m_wait = 0; m_wcnt = 0;
                end else if (m_wcnt == MEM_TIMEOUT) begin
                    m_wait = 0; m_err = 1;
                end else begin
                    m_wcnt++;
                end
            end else if (mem_req_i && !mem_ack_i) begin
                m_wait = 1; m_wcnt = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
        id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_is_load_i = 1'b0;
        ex_pc_sel_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic set_load_use();
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd5;
        id_rs1_addr_i = 5'd5; id_uses_rs1_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1; mem_req_i = 1'b1; ex_pc_sel_i = 1'b1;
        #1;
        tests_run++;
        if (outs_s !== O_IDLE) begin fails++; $display("FAIL reset_forced_outs got=%b exp=%b", outs_s, O_IDLE); end
        tick();
        rst_i = 1'b0; clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt_o !== 3'd0 || flush_cnt_o !== 3'd0 || outs_s !== O_IDLE) begin
            fails++; $display("FAIL reset_state stall=%0d flush=%0d outs=%b exp 0 0 %b", stall_cnt_o, flush_cnt_o, outs_s, O_IDLE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        tests_run++;
        if (outs_s !== O_LU) begin fails++; $display("FAIL load_use_outs got=%b exp=%b", outs_s, O_LU); end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt_o !== 3'd1 || outs_s !== O_IDLE) begin
            fails++; $display("FAIL load_use_after stall=%0d outs=%b exp 1 %b", stall_cnt_o, outs_s, O_IDLE);
        end
    endtask

    task automatic test_x0_no_use();
        do_reset();
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0; id_uses_rs1_i = 1'b1;
        #1;
        tests_run++;
        if (outs_s !== O_IDLE) begin fails++; $display("FAIL x0_no_hazard got=%b exp=%b", outs_s, O_IDLE); end
        tick();
        ex_rd_addr_i = 5'd7; id_rs2_addr_i = 5'd7; id_uses_rs2_i = 1'b0; id_rs1_addr_i = 5'd3;
        #1;
        tests_run++;
        if (outs_s !== O_IDLE) begin fails++; $display("FAIL unused_rs2_no_hazard got=%b exp=%b", outs_s, O_IDLE); end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt_o !== 3'd0) begin fails++; $display("FAIL x0_stall_cnt got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_load_use();
        ex_pc_sel_i = 1'b1;
        #1;
        tests_run++;
        if (outs_s !== O_BR) begin fails++; $display("FAIL branch_over_lu got=%b exp=%b", outs_s, O_BR); end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (flush_cnt_o !== 3'd1 || stall_cnt_o !== 3'd0) begin
            fails++; $display("FAIL branch_counts flush=%0d stall=%0d exp 1 0", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_mem_wait();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            mem_req_i = 1'b1; mem_ack_i = 1'b0; ex_pc_sel_i = (pass == 1);
            for (int i = 0; i < 3; i++) begin
                #1;
                tests_run++;
                if (outs_s !== O_BLOCK) begin fails++; $display("FAIL mem_wait_block p%0d c%0d got=%b exp=%b", pass, i, outs_s, O_BLOCK); end
                tick();
            end
            mem_ack_i = 1'b1;
            #1;
            tests_run++;
            if (outs_s !== ((pass == 1) ? O_BR : O_IDLE)) begin
                fails++; $display("FAIL mem_release p%0d got=%b exp=%b", pass, outs_s, (pass == 1) ? O_BR : O_IDLE);
            end
            tick();
            clear_inputs();
            #1;
            tests_run++;
            if (stall_cnt_o !== 3'd3 || flush_cnt_o !== 3'(pass) || outs_s !== O_IDLE) begin
                fails++; $display("FAIL mem_after p%0d stall=%0d flush=%0d outs=%b exp 3 %0d %b", pass, stall_cnt_o, flush_cnt_o, outs_s, pass, O_IDLE);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req_i = 1'b1; mem_ack_i = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            #1;
            tests_run++;
            if (outs_s !== O_BLOCK) begin fails++; $display("FAIL timeout_block c%0d got=%b exp=%b", i, outs_s, O_BLOCK); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = (i == 1);
            #1;
            tests_run++;
            if (outs_s !== O_ERR || stall_cnt_o !== 3'd5) begin
                fails++; $display("FAIL err_state c%0d outs=%b stall=%0d exp %b 5", i, outs_s, stall_cnt_o, O_ERR);
            end
            tick();
        end
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (outs_s !== O_IDLE) begin fails++; $display("FAIL err_reset_forced got=%b exp=%b", outs_s, O_IDLE); end
        tick();
        rst_i = 1'b0; clear_inputs();
        #1;
        tests_run++;
        if (outs_s !== O_IDLE || stall_cnt_o !== 3'd0 || flush_cnt_o !== 3'd0) begin
            fails++; $display("FAIL err_cleared outs=%b stall=%0d flush=%0d", outs_s, stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_load_use();
            tick();
            clear_inputs();
            tick();
        end
        tests_run++;
        if (stall_cnt_o !== 3'd7) begin fails++; $display("FAIL stall_saturate got=%0d exp=7", stall_cnt_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_i         = ($urandom_range(0, 199) == 0);
            ex_rd_addr_i  = 5'($urandom_range(0, 3));
            id_rs1_addr_i = 5'($urandom_range(0, 3));
            id_rs2_addr_i = 5'($urandom_range(0, 3));
            id_uses_rs1_i = $urandom_range(0, 1) == 1;
            id_uses_rs2_i = $urandom_range(0, 1) == 1;
            ex_is_load_i  = $urandom_range(0, 1) == 1;
            ex_pc_sel_i   = $urandom_range(0, 4) == 0;
            mem_req_i     = $urandom_range(0, 2) == 0;
            mem_ack_i     = $urandom_range(0, 9) < 4;
            #1;
            tests_run++;
            if (outs_s !== model_out() || stall_cnt_o !== 3'(m_stall) || flush_cnt_o !== 3'(m_flush)) begin
                fails++;
                $display("FAIL random c%0d outs=%b stall=%0d flush=%0d exp %b %0d %0d",
                         n, outs_s, stall_cnt_o, flush_cnt_o, model_out(), m_stall, m_flush);
            end
            tick();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        m_err = 0; m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        rst_i = 1'b1;
        clear_inputs();
        @(negedge clk_i);
        test_reset();
        test_load_use();
        test_x0_no_use();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
